// File: rtl/pwm_pkg.sv
// Shared encodings for the multi-channel PWM block.
// Pure definitions: no logic, no latency, no flow control.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;
    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

endpackage

// File: rtl/pwm_multi_ch_if.sv
// Configuration inputs and PWM outputs between the register bank and the PWM block.
// Wires only: the PWM block always accepts config and never applies backpressure.
interface pwm_multi_ch_if #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 16
);
    logic [CNT_W-1:0]        period;
    logic [CH_NUM*CNT_W-1:0] duty;
    logic                    mode;
    logic                    load;
    logic                    run;
    logic [CH_NUM-1:0]       en;
    logic [CH_NUM-1:0]       pol;
    logic [CH_NUM-1:0]       pwm;
    logic                    period_tick;
    logic                    load_ack;

    modport master (
        output period, duty, mode, load, run, en, pol,
        input  pwm, period_tick, load_ack
    );

    modport slave (
        input  period, duty, mode, load, run, en, pol,
        output pwm, period_tick, load_ack
    );

endinterface

// File: rtl/pwm_ch_out.sv
// One PWM output: compares the shared counter against this channel's duty.
// Registered, 1 cycle from cnt to pwm; en/pol are live and no backpressure exists.
module pwm_ch_out #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] duty,
    input  logic             en,
    input  logic             pol,
    input  logic             run,
    output logic             pwm
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm <= 1'b0;
        end else if (run && en) begin
            pwm <= (cnt < duty) ^ pol;
        end else begin
            pwm <= pol;
        end
    end

endmodule

// File: rtl/pwm_multi_ch.sv
// CH_NUM-channel PWM on one shared edge/center-aligned counter with double-buffered config.
// Outputs lag the counter by 1 cycle; loads are always accepted and applied at a period boundary.
module pwm_multi_ch #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    pwm_multi_ch_if.slave bus
);
    import pwm_pkg::*;

    logic [CNT_W-1:0]        stg_period;
    logic [CNT_W-1:0]        act_period;
    logic [CH_NUM*CNT_W-1:0] stg_duty;
    logic [CH_NUM*CNT_W-1:0] act_duty;
    logic                    stg_mode;
    logic                    act_mode;
    logic                    pending;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        next_cnt;
    logic                    dir;
    logic                    next_dir;
    logic                    at_zero;
    logic                    apply;
    logic                    tick_q;
    logic                    ack_q;
    logic [CH_NUM-1:0]       pwm_q;

    // Counter walks 0..P (edge) or 0..P..1 (center); P==0 parks it at 0.
    always_comb begin
        next_cnt = '0;
        next_dir = DIR_UP;
        if (bus.run && (act_period != '0)) begin
            if (act_mode == MODE_EDGE) begin
                next_cnt = (cnt >= act_period) ? '0 : cnt + CNT_W'(1);
            end else begin
                if ((dir == DIR_UP) && (cnt < act_period)) begin
                    next_cnt = cnt + CNT_W'(1);
                end else begin
                    next_cnt = cnt - CNT_W'(1);
                end
                if (next_cnt == '0) begin
                    next_dir = DIR_UP;
                end else if ((dir == DIR_UP) && (cnt >= act_period)) begin
                    next_dir = DIR_DOWN;
                end else begin
                    next_dir = dir;
                end
            end
        end
    end

    assign at_zero = (next_cnt == '0);
    // While stopped the counter sits at 0, so config can be swapped on any edge.
    assign apply   = at_zero || !bus.run;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            dir        <= DIR_UP;
            stg_period <= '0;
            stg_duty   <= '0;
            stg_mode   <= MODE_EDGE;
            act_period <= '0;
            act_duty   <= '0;
            act_mode   <= MODE_EDGE;
            pending    <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            cnt    <= next_cnt;
            dir    <= next_dir;
            tick_q <= bus.run && at_zero;
            ack_q  <= 1'b0;
            if (bus.load) begin
                stg_period <= bus.period;
                stg_duty   <= bus.duty;
                stg_mode   <= bus.mode;
            end
            if (apply && bus.load) begin
                act_period <= bus.period;
                act_duty   <= bus.duty;
                act_mode   <= bus.mode;
                pending    <= 1'b0;
                ack_q      <= 1'b1;
            end else if (apply && pending) begin
                act_period <= stg_period;
                act_duty   <= stg_duty;
                act_mode   <= stg_mode;
                pending    <= 1'b0;
                ack_q      <= 1'b1;
            end else if (bus.load) begin
                pending <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        pwm_ch_out #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .cnt  (cnt),
            .duty (act_duty[i*CNT_W +: CNT_W]),
            .en   (bus.en[i]),
            .pol  (bus.pol[i]),
            .run  (bus.run),
            .pwm  (pwm_q[i])
        );
    end

    assign bus.pwm         = pwm_q;
    assign bus.period_tick = tick_q;
    assign bus.load_ack    = ack_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_pwm_multi_ch;

    localparam int CH = 4;
    localparam int W  = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pwm_multi_ch_if #(.CH_NUM(CH), .CNT_W(W)) bus ();

    pwm_multi_ch #(
        .CH_NUM(CH),
        .CNT_W (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] pwm;
        logic       tick;
        logic       ack;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e_cur;
    int   checks = 0;
    int   errors = 0;
    int   cseq[8] = '{0, 1, 2, 3, 4, 3, 2, 1};

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e_cur = sb.pop_front();
            checks++;
            if (bus.pwm !== e_cur.pwm) begin
                errors++;
                $display("FAIL %s pwm: got %b expected %b at %0t", e_cur.name, bus.pwm, e_cur.pwm, $time);
            end
            checks++;
            if (bus.period_tick !== e_cur.tick) begin
                errors++;
                $display("FAIL %s period_tick: got %b expected %b at %0t", e_cur.name, bus.period_tick, e_cur.tick, $time);
            end
            checks++;
            if (bus.load_ack !== e_cur.ack) begin
                errors++;
                $display("FAIL %s load_ack: got %b expected %b at %0t", e_cur.name, bus.load_ack, e_cur.ack, $time);
            end
        end
    end

    // Inputs set before the call are sampled by the next edge; the outputs of that edge are expected.
    task automatic cyc(input logic [3:0] p, input logic t, input logic a, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e.pwm  = p;
        e.tick = t;
        e.ack  = a;
        e.name = nm;
        sb.push_back(e);
    endtask

    initial begin
        logic [3:0] ep;
        int         d;
        int         c;

        rst        = 1'b1;
        bus.period = '0;
        bus.duty   = '0;
        bus.mode   = 1'b0;
        bus.load   = 1'b0;
        bus.run    = 1'b0;
        bus.en     = '0;
        bus.pol    = '0;
        cyc(4'b0000, 1'b0, 1'b0, "reset0");
        cyc(4'b0000, 1'b0, 1'b0, "reset1");

        // Edge mode P=9 D0=3, loaded while stopped.
        rst              = 1'b0;
        bus.load         = 1'b1;
        bus.period       = 16'd9;
        bus.duty[15:0]   = 16'd3;
        bus.en           = 4'b0001;
        cyc(4'b0000, 1'b0, 1'b1, "cfg_ack");
        bus.load = 1'b0;
        bus.run  = 1'b1;

        // k = counter value index; mid-period load of D=7 at cnt=5 lands at k=29.
        for (int k = 0; k < 40; k++) begin
            if (k == 25) begin
                bus.load       = 1'b1;
                bus.duty[15:0] = 16'd7;
            end else begin
                bus.load = 1'b0;
            end
            d  = (k >= 30) ? 7 : 3;
            ep = {3'b000, (k % 10) < d};
            cyc(ep, (k % 10) == 9, k == 29, (k < 20) ? "edge_d3" : "midload");
        end

        // Load on the boundary edge, then two loads in one period, then switch to center mode.
        for (int k = 40; k < 80; k++) begin
            bus.load = 1'b0;
            if (k == 49) begin
                bus.load       = 1'b1;
                bus.duty[15:0] = 16'd2;
            end
            if (k == 62) begin
                bus.load       = 1'b1;
                bus.duty[15:0] = 16'd5;
            end
            if (k == 65) begin
                bus.load       = 1'b1;
                bus.duty[15:0] = 16'd4;
            end
            if (k == 79) begin
                bus.load       = 1'b1;
                bus.mode       = 1'b1;
                bus.period     = 16'd4;
                bus.duty[15:0] = 16'd2;
            end
            d  = (k < 50) ? 7 : ((k < 70) ? 2 : 4);
            ep = {3'b000, (k % 10) < d};
            cyc(ep, (k % 10) == 9, (k == 49) || (k == 69) || (k == 79),
                (k < 60) ? "bnd_load" : "two_loads");
        end

        // Center mode P=4 D=2; at the last boundary load an edge-mode limits config.
        for (int j = 0; j < 24; j++) begin
            bus.load = 1'b0;
            if (j == 23) begin
                bus.load   = 1'b1;
                bus.mode   = 1'b0;
                bus.period = 16'd5;
                bus.duty   = {16'd3, 16'd3, 16'd6, 16'd0};
            end
            c  = cseq[j % 8];
            ep = {3'b000, c < 2};
            cyc(ep, (j % 8) == 7, j == 23, "center");
        end

        // Limits: D=0, D=P+1, pol inversion, then en=0 on two channels, then P=0.
        bus.en  = 4'b1111;
        bus.pol = 4'b1000;
        for (int m = 0; m < 24; m++) begin
            bus.load = 1'b0;
            if (m == 12) bus.en = 4'b0011;
            if (m == 23) begin
                bus.load   = 1'b1;
                bus.period = 16'd0;
                bus.duty   = {16'd0, 16'd0, 16'd1, 16'd0};
            end
            c = m % 6;
            if (m < 12) ep = {!(c < 3), (c < 3), 1'b1, 1'b0};
            else        ep = 4'b1010;
            cyc(ep, c == 5, m == 23, (m < 12) ? "limits" : "en_off");
        end
        bus.load = 1'b0;
        for (int n = 0; n < 4; n++) cyc(4'b1010, 1'b1, 1'b0, "p_zero");

        // Stopped counter with load, then reset in mid-period.
        bus.run        = 1'b0;
        bus.load       = 1'b1;
        bus.period     = 16'd9;
        bus.duty       = '0;
        bus.duty[15:0] = 16'd3;
        bus.en         = 4'b0001;
        bus.pol        = 4'b0000;
        cyc(4'b0000, 1'b0, 1'b1, "run0_load");
        bus.load = 1'b0;
        cyc(4'b0000, 1'b0, 1'b0, "run0_hold");
        cyc(4'b0000, 1'b0, 1'b0, "run0_hold");
        bus.run = 1'b1;
        cyc(4'b0001, 1'b0, 1'b0, "run_start");
        cyc(4'b0001, 1'b0, 1'b0, "run_start");
        rst = 1'b1;
        cyc(4'b0000, 1'b0, 1'b0, "rst_mid");
        cyc(4'b0000, 1'b0, 1'b0, "rst_hold");
        rst = 1'b0;
        cyc(4'b0000, 1'b1, 1'b0, "post_rst");
        bus.load = 1'b1;
        cyc(4'b0000, 1'b1, 1'b1, "post_rst_load");
        bus.load = 1'b0;
        for (int k = 0; k < 10; k++) begin
            ep = {3'b000, k < 3};
            cyc(ep, k == 9, 1'b0, "post_rst_edge");
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
